// File: rtl/textbuffer_pkg.sv
// Shared constants, control codes and FSM states for the text console writer.
// Geometry here is the default 20x16 buffer at 0x400.
package textbuffer_pkg;

  localparam int TB_WIDTH = 20;
  localparam int TB_HEIGHT = 16;
  localparam logic [11:0] TB_BASEADDR = 12'h400;
  localparam logic [11:0] TB_ATTR_OFFSET = 12'(TB_WIDTH * TB_HEIGHT);
  localparam logic [7:0] TB_BLANK = 8'h20;
  localparam logic [7:0] TB_ATTR_RST = 8'h0F;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] CC_PRINT = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WR_CHAR,
    WR_ATTR,
    SCROLL_RD,
    SCROLL_WR,
    CLEAR_LINE,
    CLEAR_ALL
  } state_t;

endpackage

// File: rtl/text_cursor.sv
// Cursor position register for the text console writer.
// Overflow flags a step past the last row; the row then wraps to 0.
module text_cursor
  import textbuffer_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH,
  parameter int HEIGHT = TB_HEIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  input  logic       cr,
  input  logic       lf,
  input  logic       bs,
  input  logic       home,
  input  logic       set_last_row,
  output logic [4:0] col,
  output logic [3:0] row,
  output logic       overflow
);

  localparam logic [4:0] LAST_COL = 5'(WIDTH - 1);
  localparam logic [3:0] LAST_ROW = 4'(HEIGHT - 1);

  logic [3:0] row_inc;

  assign row_inc = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
  assign overflow = (row == LAST_ROW) &&
                    (lf || (adv && col == LAST_COL));

  // set_last_row wins over adv/lf so a scroll keeps the last row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (home) begin
      col <= '0;
      row <= '0;
    end else if (set_last_row) begin
      col <= '0;
      row <= LAST_ROW;
    end else if (adv) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= row_inc;
      end else begin
        col <= col + 5'd1;
      end
    end else if (lf) begin
      col <= '0;
      row <= row_inc;
    end else if (cr) begin
      col <= '0;
    end else if (bs && col != 5'd0) begin
      col <= col - 5'd1;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte stream to text buffer bus master: cursor, control codes, clears.
// Define TEXT_CONSOLE_SCROLL_EN to scroll on row overflow instead of wrapping.
module text_console_writer
  import textbuffer_pkg::*;
#(
  parameter int WIDTH = TB_WIDTH,
  parameter int HEIGHT = TB_HEIGHT,
  parameter logic [11:0] BASEADDR = TB_BASEADDR,
  parameter logic [7:0] BLANK = TB_BLANK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ch,
  input  logic        ch_valid,
  output logic        ch_ready,
  input  logic [7:0]  attr,
  input  logic        attr_we,
  output logic [11:0] addr,
  output logic        we,
  output logic        oe,
  output logic [7:0]  dout,
  input  logic [7:0]  din,
  output logic [4:0]  cur_col,
  output logic [3:0]  cur_row,
  output logic        busy
);

  localparam logic [11:0] CELLS = 12'(WIDTH * HEIGHT);
  localparam logic [11:0] ROW_W = 12'(WIDTH);
  localparam logic [11:0] ALL_LAST = 12'(2 * WIDTH * HEIGHT - 1);
  localparam logic [11:0] LINE_LAST = 12'(2 * WIDTH - 1);
`ifdef TEXT_CONSOLE_SCROLL_EN
  localparam logic [11:0] MOVE_CELLS = 12'(WIDTH * (HEIGHT - 1));
  localparam logic [11:0] MOVE_LAST = 12'(2 * WIDTH * (HEIGHT - 1) - 1);
  localparam logic [11:0] CLR_BASE = BASEADDR + MOVE_CELLS;
`else
  localparam logic [11:0] CLR_BASE = BASEADDR;
`endif

  state_t state;

  logic [11:0] idx;
  logic [11:0] nidx;
  logic [11:0] pos;
  logic [11:0] line_off;
  logic [7:0]  line_dout;
  logic [7:0]  all_dout;
  logic [7:0]  dout_q;
  logic [7:0]  cur_attr;

  logic take;
  logic printable;
  logic is_ff;
  logic is_lf;
  logic is_cr;
  logic is_bs;
  logic adv;
  logic ovf;
  logic last_row;

  state_t      ovf_state;
  logic [11:0] ovf_addr;
  logic        ovf_we;
  logic        ovf_oe;
  logic [7:0]  ovf_dout;

`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [11:0] scroll_dst;
  logic [11:0] scroll_src;
`endif

  assign ch_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign take = ch_valid && ch_ready;

  assign printable = (ch >= CC_PRINT);
  assign is_ff = (ch == CC_FF);
  assign is_lf = (ch == CC_LF);
  assign is_cr = (ch == CC_CR);
  assign is_bs = (ch == CC_BS);
  assign adv = (state == WR_ATTR);

  // Read data arrives one cycle after oe, so it feeds the bus directly.
  assign dout = (state == SCROLL_WR) ? din : dout_q;

`ifdef TEXT_CONSOLE_SCROLL_EN
  assign last_row = ovf;
`else
  assign last_row = 1'b0;
`endif

  text_cursor #(
    .WIDTH(WIDTH),
    .HEIGHT(HEIGHT)
  ) u_cursor (
    .clk(clk),
    .reset(reset),
    .adv(adv),
    .cr(take && is_cr),
    .lf(take && is_lf),
    .bs(take && is_bs),
    .home(take && is_ff),
    .set_last_row(last_row),
    .col(cur_col),
    .row(cur_row),
    .overflow(ovf)
  );

  always_comb begin
    nidx = idx + 12'd1;
    pos = 12'(cur_row) * ROW_W + 12'(cur_col);
    if (nidx < ROW_W) begin
      line_off = nidx;
      line_dout = BLANK;
    end else begin
      line_off = nidx - ROW_W + CELLS;
      line_dout = cur_attr;
    end
    all_dout = (nidx < CELLS) ? BLANK : cur_attr;
  end

  // First bus cycle of the row-overflow sequence.
  always_comb begin
    ovf_state = CLEAR_LINE;
    ovf_addr = CLR_BASE;
    ovf_we = 1'b1;
    ovf_oe = 1'b0;
    ovf_dout = BLANK;
`ifdef TEXT_CONSOLE_SCROLL_EN
    ovf_state = SCROLL_RD;
    ovf_addr = BASEADDR + ROW_W;
    ovf_we = 1'b0;
    ovf_oe = 1'b1;
    ovf_dout = dout_q;
`endif
  end

`ifdef TEXT_CONSOLE_SCROLL_EN
  // Attribute cells sit WIDTH past the moved character block.
  always_comb begin
    scroll_dst = idx;
    if (idx >= MOVE_CELLS)
      scroll_dst = idx + ROW_W;
    scroll_src = nidx + ROW_W;
    if (nidx >= MOVE_CELLS)
      scroll_src = nidx + ROW_W + ROW_W;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      we <= 1'b0;
      oe <= 1'b0;
      dout_q <= '0;
      idx <= '0;
      cur_attr <= TB_ATTR_RST;
    end else begin
      if (attr_we)
        cur_attr <= attr;
      unique case (state)
        IDLE: begin
          if (take) begin
            unique case (1'b1)
              printable: begin
                state <= WR_CHAR;
                addr <= BASEADDR + pos;
                we <= 1'b1;
                dout_q <= ch;
              end
              is_ff: begin
                state <= CLEAR_ALL;
                addr <= BASEADDR;
                we <= 1'b1;
                dout_q <= BLANK;
                idx <= '0;
              end
              (is_lf && ovf): begin
                state <= ovf_state;
                addr <= ovf_addr;
                we <= ovf_we;
                oe <= ovf_oe;
                dout_q <= ovf_dout;
                idx <= '0;
              end
              default: ;
            endcase
          end
        end
        WR_CHAR: begin
          state <= WR_ATTR;
          addr <= BASEADDR + CELLS + pos;
          dout_q <= cur_attr;
        end
        WR_ATTR: begin
          if (ovf) begin
            state <= ovf_state;
            addr <= ovf_addr;
            we <= ovf_we;
            oe <= ovf_oe;
            dout_q <= ovf_dout;
            idx <= '0;
          end else begin
            state <= IDLE;
            we <= 1'b0;
          end
        end
`ifdef TEXT_CONSOLE_SCROLL_EN
        SCROLL_RD: begin
          state <= SCROLL_WR;
          oe <= 1'b0;
          we <= 1'b1;
          addr <= BASEADDR + scroll_dst;
        end
        SCROLL_WR: begin
          dout_q <= din;
          if (idx == MOVE_LAST) begin
            state <= CLEAR_LINE;
            addr <= CLR_BASE;
            dout_q <= BLANK;
            idx <= '0;
          end else begin
            state <= SCROLL_RD;
            we <= 1'b0;
            oe <= 1'b1;
            addr <= BASEADDR + scroll_src;
            idx <= nidx;
          end
        end
`endif
        CLEAR_LINE: begin
          if (idx == LINE_LAST) begin
            state <= IDLE;
            we <= 1'b0;
          end else begin
            addr <= CLR_BASE + line_off;
            dout_q <= line_dout;
            idx <= nidx;
          end
        end
        CLEAR_ALL: begin
          if (idx == ALL_LAST) begin
            state <= IDLE;
            we <= 1'b0;
          end else begin
            addr <= BASEADDR + nidx;
            dout_q <= all_dout;
            idx <= nidx;
          end
        end
        default: begin
          state <= IDLE;
          we <= 1'b0;
          oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Bus master that feeds the 20x16 text buffer: turns a byte stream (CPU or UART terminal output) into writes to video RAM and attribute RAM.
- Tracks a cursor and handles control codes: CR, LF, backspace and clear screen.
- Performs scroll-up by read-modify-copy through the text buffer's own addr/we/oe port.
- Sits between the character source and the text buffer's CPU-side port.

Parameters:
- WIDTH, 20, columns per row.
- HEIGHT, 16, rows.
- BASEADDR, 12'h400, bus address of character cell 0; attribute cell n is at BASEADDR+WIDTH*HEIGHT+n.
- BLANK, 8'h20, fill character for clears.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- ch  in  8  incoming character/control byte.
- ch_valid  in  1  ch is presented.
- ch_ready  out  1  writer accepts ch this cycle (transfer = ch_valid & ch_ready).
- attr  in  8  attribute byte: [3:0] fg, [7:4] bg.
- attr_we  in  1  load attr into the current-attribute register.
- addr  out  12  text buffer address.
- we  out  1  write strobe.
- oe  out  1  read strobe.
- dout  out  8  write data to the text buffer.
- din  in  8  read data from the text buffer; valid the cycle after oe.
- cur_col  out  5  cursor column, 0..WIDTH-1.
- cur_row  out  4  cursor row, 0..HEIGHT-1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (reset==0 at posedge):
- state=IDLE; cursor (0,0); cur_attr=8'h0F.
- addr=0, we=0, oe=0, dout=0, ch_ready=1, busy=0.
- Reset mid-operation aborts immediately; partially scrolled/cleared RAM contents are left as-is.

Attribute load:
- attr_we loads cur_attr in any state and takes effect for the next cell written.
- If attr_we coincides with ch acceptance, the new attr applies to that ch.

Handshake:
- ch_ready = (state==IDLE).
- One byte is accepted per transfer; ch is registered on acceptance.

Byte handling:
- Printable (ch>=8'h20): WR_CHAR, then WR_ATTR.
  - WR_CHAR: addr=BASEADDR+pos, we=1, dout=ch, where pos=row*WIDTH+col.
  - WR_ATTR: addr=BASEADDR+WIDTH*HEIGHT+pos, we=1, dout=cur_attr.
  - Then advance the cursor. ch_ready returns 3 cycles after acceptance.
- 8'h0D CR: col=0; single cycle.
- 8'h0A LF: col=0, row+1.
- 8'h08 BS: if col>0 then col-1. At col==0 nothing happens; no wrap to the previous row.
- 8'h0C FF: CLEAR_ALL.
  - Writes BLANK to all WIDTH*HEIGHT character cells, then cur_attr to all attribute cells, one write per cycle.
  - Cursor goes to (0,0). Takes 640 cycles.
- Other codes below 8'h20: ignored, single cycle.

Cursor advance after a printable:
- col+1; at col==WIDTH-1 this wraps to col=0, row+1.

Row overflow (row+1==HEIGHT), from an advance or from LF: see SCROLL_EN.

Scroll sequence (states SCROLL_RD, SCROLL_WR, CLEAR_LINE):
- For i in 0..WIDTH*(HEIGHT-1)-1, first for character cells, then for attribute cells:
  - SCROLL_RD: addr=src(i+WIDTH), oe=1.
  - SCROLL_WR: addr=dst(i), we=1, dout=din.
- CLEAR_LINE: last row character cells get BLANK, attribute cells get cur_attr.
- Cursor ends at (0, HEIGHT-1).
- Duration: 2*2*300 + 2*20 = 1240 cycles.

Bus rules:
- we and oe are never high together.
- addr/dout are only meaningful while we or oe is high; they hold their last value otherwise.

Optional Feature:
- Macro TEXT_CONSOLE_SCROLL_EN.
- Defined: row overflow runs the scroll sequence.
- Undefined: row overflow wraps the cursor to row 0, and only that row is cleared via CLEAR_LINE (40 cycles). SCROLL_RD/SCROLL_WR are not built.

Decomposition:
Package textbuffer_pkg holds:
- TB_WIDTH, TB_HEIGHT, TB_BASEADDR, TB_ATTR_OFFSET.
- Control code constants CC_BS, CC_LF, CC_FF, CC_CR.
- State enum: IDLE, WR_CHAR, WR_ATTR, SCROLL_RD, SCROLL_WR, CLEAR_LINE, CLEAR_ALL.

Sub-module text_cursor: owns col/row, with inputs adv, cr, lf, bs, home, set_last_row, and an overflow output. The FSM and bus sequencing stay in the top.

Test Plan:
- Reset, then ch=8'h41 with cur_attr=8'h0F -> write 0x41 @0x400, then 0x0F @0x540; cursor (1,0); ch_ready high again 3 cycles after acceptance.
- 20 printables, then attr_we with 8'h2C plus one 'B' -> cursor wrap to (0,1); 'B' @0x414 with attr 0x2C @0x554.
- Cursor at (5,3), send 8'h08, 8'h0D, 8'h08 -> (4,3), then (0,3), then (0,3) unchanged.
- ch=8'h0C -> busy for 640 cycles; 0x400..0x53F = 0x20; 0x540..0x67F = cur_attr; cursor (0,0).
- SCROLL_EN defined, cell 0x414 = 'X', cursor (0,15), send LF -> 0x400 = 'X'; last row 0x52C..0x53F = 0x20; cursor (0,15); busy for 1240 cycles.
- SCROLL_EN undefined, same LF -> cursor (0,0); only row 0 is cleared. Separately, pull reset low mid-scroll -> next cycle we=0, oe=0, ch_ready=1, cursor (0,0).
